// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package mips_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StData,
        StCsum,
        StDone,
        StErr
    } ld_state_e;

    localparam int unsigned HdrW = 16;

endpackage

// File: rtl/im_byte_pack.sv
// Collects a big-endian byte stream into 32-bit words; strobes when the 4th byte lands.
module im_byte_pack
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_ready_o
);

    // Only the first three bytes need storage; the fourth is taken straight from byte_i.
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = {shift_q, byte_i};
    assign word_ready_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// Streams a length-prefixed program into instruction memory while holding the CPU.
// Optional trailing checksum byte enabled by defining IM_LOADER_CHECKSUM_EN.
module im_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    ld_state_e         state_q, state_d;
    logic [HdrW-1:0]   n_q, n_d;
    logic [HdrW-1:0]   widx_q, widx_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;

    logic              xfer;
    logic              pack_clr;
    logic              word_ready;
    logic [31:0]       word;
    logic [HdrW-1:0]   hdr_n;
    logic              last_word;

`ifdef IM_LOADER_CHECKSUM_EN
    localparam ld_state_e AfterData = StCsum;
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (pack_clr) begin
            csum_d = '0;
        end else if (xfer && (state_q == StData)) begin
            csum_d = csum_q + in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    localparam ld_state_e AfterData = StDone;
`endif

    assign xfer      = in_valid && in_ready;
    assign hdr_n     = {n_q[HdrW-1:HdrW-8], in_data};
    assign last_word = (widx_q == (n_q - HdrW'(1)));

    im_byte_pack u_pack (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (pack_clr),
        .byte_valid_i (xfer && (state_q == StData)),
        .byte_i       (in_data),
        .word_o       (word),
        .word_ready_o (word_ready)
    );

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        widx_d     = widx_q;
        pack_clr   = 1'b0;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StHdrHi;
                    widx_d   = '0;
                    pack_clr = 1'b1;
                end
            end
            StHdrHi: begin
                if (xfer) begin
                    n_d     = {in_data, 8'h00};
                    state_d = StHdrLo;
                end
            end
            StHdrLo: begin
                if (xfer) begin
                    n_d = hdr_n;
                    if (hdr_n == '0) begin
                        state_d = AfterData;
                    end else if (32'(hdr_n) > MAX_WORDS) begin
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (word_ready) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = widx_q[ADDR_W-1:0];
                    im_wdata_d = word;
                    widx_d     = widx_q + HdrW'(1);
                    if (last_word) begin
                        state_d = AfterData;
                    end
                end
            end
            StCsum: begin
`ifdef IM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    state_d = (in_data == csum_q) ? StDone : StErr;
                end
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            n_q        <= '0;
            widx_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            widx_q     <= widx_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

    assign in_ready = (state_q == StHdrHi) || (state_q == StHdrLo) ||
                      (state_q == StData)  || (state_q == StCsum);
    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign cpu_hold = (state_q != StDone);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StErr);

endmodule

// File: tb/tb_im_loader.sv
// Randomized scoreboard bench for im_loader; expected memory writes are queued by the
// stimulus side and matched by an independent monitor on the falling clock edge.
module tb_im_loader;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    im_loader #(
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [31:0]       exp_data_q[$];
    logic [7:0]        data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the expected queue; between writes the
    // write port must hold the last written address/data.
    initial begin
        logic [ADDR_W-1:0] last_addr;
        logic [31:0]       last_data;
        logic              prev_we;
        last_addr = '0;
        last_data = '0;
        prev_we   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_addr = '0;
                last_data = '0;
                prev_we   = 1'b0;
            end else if (im_we) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0h data %h expected none",
                             im_addr, im_wdata);
                end else begin
                    last_addr = exp_addr_q.pop_front();
                    last_data = exp_data_q.pop_front();
                    check("write_addr", 32'(im_addr), 32'(last_addr));
                    check("write_data", im_wdata, last_data);
                end
                prev_we = 1'b1;
            end else begin
                check("hold_addr", 32'(im_addr), 32'(last_addr));
                check("hold_data", im_wdata, last_data);
                prev_we = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int cnt;
        repeat ($urandom_range(gap, 0)) step();
        in_valid = 1'b1;
        in_data  = b;
        cnt      = 0;
        @(negedge clk);
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("byte_accept", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic fill_random(input int n);
        data_q.delete();
        for (int k = 0; k < 4 * n; k++) data_q.push_back(8'($urandom_range(255, 0)));
    endtask

    // Reference: word i is bytes 4i..4i+3 big-endian at address i; oversize header errors;
    // with checksum enabled the trailing byte must equal the byte sum mod 256.
    task automatic run_load(input string tag, input logic [15:0] n, input int gap,
                            input logic csum_ok, input logic mid_start);
        logic [7:0] csum;
        logic       exp_err;
        int         cnt;
        csum    = 8'h00;
        exp_err = (32'(n) > MAX_WORDS) || !csum_ok;
        pulse_start();
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        if (32'(n) <= MAX_WORDS) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_addr_q.push_back(ADDR_W'(i));
                exp_data_q.push_back({data_q[4*i], data_q[4*i+1], data_q[4*i+2],
                                      data_q[4*i+3]});
            end
            for (int k = 0; k < 4 * int'(n); k++) begin
                send_byte(data_q[k], gap);
                csum = csum + data_q[k];
                if (mid_start && k == 1) pulse_start();
            end
`ifdef IM_LOADER_CHECKSUM_EN
            send_byte(csum_ok ? csum : csum + 8'd1, gap);
`endif
        end
        cnt = 0;
        @(negedge clk);
        while (!done && !err && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_done"}, 32'(done), 32'(!exp_err));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_pending_writes"}, exp_addr_q.size(), 32'd0);
        exp_addr_q.delete();
        exp_data_q.delete();
        step();
    endtask

    initial begin
        #2;
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        step();
        rst_n = 1'b1;

        // Idle must not consume bytes without a start.
        in_valid = 1'b1;
        repeat (5) step();
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
        in_valid = 1'b0;

        data_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_load("two_words", 16'd2, 0, 1'b1, 1'b1);

        data_q.delete();
        run_load("empty", 16'd0, 0, 1'b1, 1'b0);

        run_load("oversize", 16'h0401, 0, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = int'($urandom_range(4, 1));
            fill_random(n);
            run_load("random", 16'(n), (t == 0) ? 0 : 5, 1'b1, 1'b0);
        end

        // Reset in the middle of a word: no write, back to IDLE immediately.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_cpu_hold", 32'(cpu_hold), 32'd1);
        check("abort_im_we", 32'(im_we), 32'd0);
        check("abort_im_addr", 32'(im_addr), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("abort_idle", 32'(in_ready), 32'd0);
        fill_random(1);
        run_load("reload", 16'd1, 3, 1'b1, 1'b0);

        fill_random(int'(MAX_WORDS));
        run_load("max_words", 16'(MAX_WORDS), 0, 1'b1, 1'b0);

`ifdef IM_LOADER_CHECKSUM_EN
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load("csum_good", 16'd1, 0, 1'b1, 1'b0);
        run_load("csum_bad", 16'd1, 0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
